// File: rtl/tt_button_debounce_counter.sv
// tt_button_debounce_counter
// Input-conditioning stage: synchronises two raw buttons, debounces them,
// produces registered rising-edge pulses and counts presses per channel.
// One 4-bit press count is shown on io_out[7:4], selected by disp_sel.
//
// Optional build macro: TT_DEB_SATURATE_EN
//   undefined : press counters wrap 15 -> 0
//   defined   : press counters stop at 15 (clr still zeroes them)
//
// Debounce states (per channel, decoded from synced input vs. debounced level):
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_STABLE  | synced == deb; timer held at 0
//   ST_PENDING | synced != deb; timer counts up, commit when it reaches N-1
//
// io_in : [0] clk, [1] rst_n, [2] btn_a, [3] btn_b, [4] disp_sel, [5] clr,
//         [7:6] deb_sel (N = DEB_BASE << deb_sel)
// io_out: [0] deb_a, [1] deb_b, [2] rise_a, [3] rise_b, [7:4] selected count
module tt_button_debounce_counter #(
    parameter int DEB_BASE  = 2,
    parameter int DEB_CNT_W = 5,
    parameter int CNT_W     = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    logic clk;
    logic rst_n;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];

    // Two-flop synchronisers; index 0 is channel A, index 1 is channel B.
    logic [1:0] btn_s1_q, btn_s2_q;
    logic       clr_s1_q, clr_s2_q;
    logic       disp_s1_q, disp_s2_q;
    logic [1:0] sel_s1_q, sel_s2_q;

    logic [DEB_CNT_W-1:0]           thr;
    deb_state_e                     state [2];
    logic [1:0][DEB_CNT_W-1:0]      dcnt_q, dcnt_d;
    logic [1:0]                     deb_q, deb_d;
    logic [1:0]                     rise_q, rise_d;
    logic [1:0][CNT_W-1:0]          pcnt_q, pcnt_d;

    // Bring every asynchronous control input into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            clr_s1_q  <= 1'b0;
            clr_s2_q  <= 1'b0;
            disp_s1_q <= 1'b0;
            disp_s2_q <= 1'b0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
        end else begin
            btn_s1_q  <= {io_in[3], io_in[2]};
            btn_s2_q  <= btn_s1_q;
            clr_s1_q  <= io_in[5];
            clr_s2_q  <= clr_s1_q;
            disp_s1_q <= io_in[4];
            disp_s2_q <= disp_s1_q;
            sel_s1_q  <= io_in[7:6];
            sel_s2_q  <= sel_s1_q;
        end
    end

    // Terminal count N-1; a ">=" compare lets a shrinking N commit at once.
    always_comb begin
        thr = DEB_CNT_W'((DEB_BASE << sel_s2_q) - 1);
    end

    // Decode per-channel debounce state from the synced input and the level.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state[ch] = (btn_s2_q[ch] != deb_q[ch]) ? ST_PENDING : ST_STABLE;
        end
    end

    // Debounce next-state: count while mismatched, toggle level on terminal count.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        rise_d = '0;
        for (int ch = 0; ch < 2; ch++) begin
            case (state[ch])
                ST_STABLE: begin
                    dcnt_d[ch] = '0;
                end
                ST_PENDING: begin
                    if (dcnt_q[ch] >= thr) begin
                        deb_d[ch]  = ~deb_q[ch];
                        dcnt_d[ch] = '0;
                        rise_d[ch] = ~deb_q[ch];
                    end else begin
                        dcnt_d[ch] = dcnt_q[ch] + DEB_CNT_W'(1);
                    end
                end
                default: begin
                    dcnt_d[ch] = '0;
                end
            endcase
        end
    end

    // Debounce timers, levels and registered rise pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            deb_q  <= '0;
            rise_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
        end
    end

    // Press counter next-state: clr has priority over a coincident rise.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_s2_q) begin
            pcnt_d = '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (rise_q[ch]) begin
`ifdef TT_DEB_SATURATE_EN
                    if (pcnt_q[ch] != {CNT_W{1'b1}}) begin
                        pcnt_d[ch] = pcnt_q[ch] + CNT_W'(1);
                    end
`else
                    pcnt_d[ch] = pcnt_q[ch] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Press counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // Output packing; count display is a plain mux on synced disp_sel.
    always_comb begin
        io_out[1:0] = deb_q;
        io_out[3:2] = rise_q;
        io_out[7:4] = disp_s2_q ? pcnt_q[1] : pcnt_q[0];
    end

endmodule

// File: tb/tb_tt_button_debounce_counter.sv
// Testbench for tt_button_debounce_counter.
// A timestamp-based reference model predicts io_out after every clock; directed
// scenarios add explicit timing/count checks, then a randomized phase follows.
module tb_tt_button_debounce_counter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic       disp  = 1'b0;
    logic       clr   = 1'b0;
    logic [1:0] sel   = 2'b00;

    wire  [7:0] io_in_w;
    wire  [7:0] io_out;

    assign io_in_w = {sel, clr, disp, btn_b, btn_a, rst_n, clk};

    tt_button_debounce_counter dut (
        .io_in  (io_in_w),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] sel;
        logic       clr;
        logic       disp;
        logic [1:0] btn;
    } in_t;

    in_t        hist[$];
    logic [1:0] m_deb;
    logic [1:0] m_rise;
    bit         m_pend [2];
    int         m_since [2];
    logic [3:0] m_cnt [2];
    int         edge_no;

    task automatic model_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        m_deb   = '0;
        m_rise  = '0;
        edge_no = 0;
        for (int c = 0; c < 2; c++) begin
            m_pend[c]  = 1'b0;
            m_since[c] = 0;
            m_cnt[c]   = '0;
        end
    endtask

    // Input seen by the core logic at an edge is the pin value from two edges earlier.
    task automatic model_step();
        in_t syn;
        in_t now;
        int  n;
        now.sel  = sel;
        now.clr  = clr;
        now.disp = disp;
        now.btn  = {btn_b, btn_a};
        syn = hist[0];
        n = 2 << syn.sel;
        edge_no++;
        for (int c = 0; c < 2; c++) begin
            if (syn.clr) m_cnt[c] = 4'd0;
            else if (m_rise[c]) begin
`ifdef TT_DEB_SATURATE_EN
                if (m_cnt[c] != 4'd15) m_cnt[c] = m_cnt[c] + 4'd1;
`else
                m_cnt[c] = m_cnt[c] + 4'd1;
`endif
            end
        end
        for (int c = 0; c < 2; c++) begin
            m_rise[c] = 1'b0;
            if (syn.btn[c] != m_deb[c]) begin
                if (!m_pend[c]) begin
                    m_pend[c]  = 1'b1;
                    m_since[c] = edge_no;
                end
                if (edge_no - m_since[c] + 1 >= n) begin
                    m_deb[c]  = ~m_deb[c];
                    m_rise[c] = m_deb[c];
                    m_pend[c] = 1'b0;
                end
            end else begin
                m_pend[c] = 1'b0;
            end
        end
        void'(hist.pop_front());
        hist.push_back(now);
    endtask

    function automatic logic [7:0] exp_out();
        logic [3:0] nib;
        nib = hist[0].disp ? m_cnt[1] : m_cnt[0];
        return {nib, m_rise[1], m_rise[0], m_deb[1], m_deb[0]};
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk_val("io_out", io_out, exp_out());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------- stimulus ----------------
    int  lat;
    bit  seen_rise;
    int  p_tog;

    initial begin
        model_reset();

        // Reset with random inputs
        {sel, clr, disp, btn_b, btn_a} = 6'($urandom);
        run(3);
        chk_val("rst_out", io_out, 32'h00);
        {sel, clr, disp, btn_b, btn_a} = '0;
        rst_n = 1'b1;
        cycle();
        chk_val("rst_rel", io_out, 32'h00);
        run(4);

        // Clean press, N=2: level and pulse at edge 4, count on edge 5
        btn_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk_val("clean_early", io_out[0], 0);
        end
        cycle();
        chk_val("clean_deb", io_out[0], 1);
        chk_val("clean_rise", io_out[2], 1);
        cycle();
        chk_val("clean_rise_off", io_out[2], 0);
        chk_val("clean_cnt", io_out[7:4], 1);
        btn_a = 1'b0;
        run(8);
        chk_val("clean_fall", io_out[0], 0);

        // Reset while pending aborts the count
        btn_a = 1'b1;
        run(3);
        rst_n = 1'b0;
        cycle();
        btn_a = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk_val("midrst_deb", io_out[0], 0);
        run(3);
        chk_val("midrst_deb2", io_out[0], 0);

        // Bounce, N=8: five toggles 3 clocks apart, then hold high
        sel = 2'b10;
        run(4);
        seen_rise = 1'b0;
        for (int t = 0; t < 5; t++) begin
            btn_a = ~btn_a;
            if (t < 4) begin
                for (int i = 0; i < 3; i++) begin
                    cycle();
                    if (io_out[2]) seen_rise = 1'b1;
                end
            end
        end
        lat = 0;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (io_out[2] && lat == 0) lat = k;
            if (io_out[0] == 1'b0 && io_out[2]) seen_rise = 1'b1;
        end
        chk_val("bounce_norise", seen_rise, 0);
        chk_val("bounce_lat", lat, 10);
        chk_val("bounce_deb", io_out[0], 1);
        btn_a = 1'b0;
        run(14);

        // Wrap / saturate: 17 presses of B shown via disp_sel=1
        sel  = 2'b00;
        clr  = 1'b1;
        run(3);
        clr  = 1'b0;
        disp = 1'b1;
        run(3);
        for (int p = 0; p < 17; p++) begin
            btn_b = 1'b1;
            run(6);
            btn_b = 1'b0;
            run(6);
        end
`ifdef TT_DEB_SATURATE_EN
        chk_val("wrap_cnt_b", io_out[7:4], 15);
`else
        chk_val("wrap_cnt_b", io_out[7:4], 1);
`endif

        // Clear priority: synced clr coincides with rise_a
        disp  = 1'b0;
        btn_a = 1'b1;
        run(6);
        btn_a = 1'b0;
        run(6);
        chk_val("clrpri_pre", io_out[7:4], 1);
        btn_a = 1'b1;
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        cycle();
        chk_val("clrpri_rise", io_out[2], 1);
        cycle();
        chk_val("clrpri_cnt", io_out[7:4], 0);
        btn_a = 1'b0;
        run(8);

        // Independence, N=4: simultaneous presses
        sel = 2'b01;
        clr = 1'b1;
        run(3);
        clr = 1'b0;
        run(3);
        btn_a = 1'b1;
        btn_b = 1'b1;
        run(5);
        cycle();
        chk_val("indep_rise", io_out[3:2], 2'b11);
        cycle();
        chk_val("indep_cnt_a", io_out[7:4], 1);
        btn_a = 1'b0;
        btn_b = 1'b0;
        run(10);
        btn_a = 1'b1;
        run(10);
        btn_a = 1'b0;
        run(10);
        chk_val("indep_cnt_a2", io_out[7:4], 2);
        disp = 1'b1;
        cycle();
        chk_val("disp_lag", io_out[7:4], 2);
        cycle();
        chk_val("disp_sw", io_out[7:4], 1);

        // Randomized phase against the model
        p_tog = 8;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p_tog = 2 << $urandom_range(0, 4);
            if ($urandom_range(0, p_tog - 1) == 0) btn_a = ~btn_a;
            if ($urandom_range(0, p_tog - 1) == 0) btn_b = ~btn_b;
            if ($urandom_range(0, 49) == 0) sel = 2'($urandom);
            if ($urandom_range(0, 19) == 0) disp = ~disp;
            clr = ($urandom_range(0, 39) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
